// File: rtl/mul_seq.sv
// mul_seq: multi-cycle WIDTH x WIDTH integer multiplier.
// Retires DIGIT bits of the multiplier per BUSY cycle and produces a 2*WIDTH-bit
// product behind valid/ready handshakes. Signed operands are handled as
// magnitudes, and the sign is restored on the final step.
module mul_seq #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    // Refuse to elaborate when the digit size does not tile the operand.
    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("mul_seq: DIGIT must lie in 1..WIDTH and divide WIDTH evenly");
        end
    endgenerate

    localparam int PW    = 2 * WIDTH;
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;

    logic [31:0]      shift_amt;
    logic [DIGIT-1:0] digit;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    sum_next;

    // Operand magnitudes at the accept edge. The most negative value negates to
    // itself, and that bit pattern is the correct unsigned magnitude.
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    assign abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b = (is_signed && b[WIDTH-1]) ? -b : b;

    // Current digit of the multiplier, its shifted partial product, and the running sum.
    always_comb begin
        shift_amt = 32'(cnt) * DIGIT;
        digit     = DIGIT'(mag_b >> shift_amt);
        partial   = (PW'(mag_a) * PW'(digit)) << shift_amt;
        sum_next  = acc + partial;
    end

    // Control FSM and datapath registers. All outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= '0;
            acc       <= '0;
            cnt       <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            neg       <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_a    <= abs_a;
                        mag_b    <= abs_b;
                        neg      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    acc <= sum_next;
                    if (cnt == LAST_CNT) begin
                        p         <= neg ? -sum_next : sum_next;
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Parametrised, multi-cycle integer multiplier; next generation of the combinational 32x32 digit-product multiplier.
- Consumes DIGIT bits of operand b per clock, accumulating WIDTH x DIGIT partial products into a 2*WIDTH-bit product.
- Adds signed/unsigned mode, valid/ready handshakes on input and output, and a synchronous abort.
- Sits between an issue stage and a result stage in the datapath; one operation in flight.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
- DIGIT, 8, bits of b retired per BUSY cycle; WIDTH % DIGIT must be 0 and 1 <= DIGIT <= WIDTH, else elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns to IDLE.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- is_signed  in  1  1 = two's-complement operands; sampled at accept.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer takes product.
- p  out  2*WIDTH  product.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, accumulator=0, step counter=0.
- STEPS = WIDTH/DIGIT.
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: in IDLE, when in_valid=1 on a rising edge:
  - register mag_a=|a| and mag_b=|b| (absolute value only when is_signed=1, else raw);
  - register neg = is_signed & (a[MSB] ^ b[MSB]);
  - clear the accumulator and counter; go to BUSY.
- BUSY, each edge: accumulator += mag_a * mag_b[counter*DIGIT +: DIGIT] << (counter*DIGIT); counter++.
  - Unsigned arithmetic in 2*WIDTH bits; no overflow is possible.
- Last step (counter = STEPS-1):
  - p <= neg ? -(final sum) : final sum, computed in 2*WIDTH bits;
  - go to DONE.
- Latency: out_valid rises exactly STEPS cycles after the accept edge (4 for the defaults).
- DONE: p and out_valid hold stable until out_ready=1 on an edge, then go to IDLE.
  - in_ready returns the following cycle; no back-to-back overlap.
  - Throughput is 1 op per STEPS+2 cycles minimum.
- Inputs outside accept: in_valid is ignored outside IDLE; a, b and is_signed may change freely after accept.
- Most-negative operand: magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits; (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) is representable in 2*WIDTH bits.
- Zero operand: full STEPS latency is still taken; p=0 and never -0 issues.
- Flush: flush=1 on an edge forces IDLE, out_valid=0, counter=0 from any state; p keeps its old value.
  - flush has priority over accept and over out_ready.
- Reset mid-operation: asynchronous return to reset values; the partial result is discarded and no out_valid is produced.
- busy = (state != IDLE).

Test Plan:
- Unsigned, defaults: a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=0 -> p=0xFFFFFFFE00000001; out_valid exactly 4 cycles after accept.
- Signed: (-2)x3 -> p=0xFFFFFFFFFFFFFFFA. Signed: 0x80000000 x 0x80000000 -> p=0x4000000000000000. Signed: -1 x -1 -> p=0x0000000000000001.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid and a/b -> p and out_valid stable, in_ready=0; release out_ready -> IDLE next cycle, in_ready=1.
- Flush at step 2 of an operation -> IDLE next cycle, no out_valid. Next op 7x6 unsigned -> p=42.
- Deassert rst_n asynchronously mid-BUSY -> all outputs at reset values immediately; after release, 3x5 -> p=15.
- WIDTH=16, DIGIT=4: 0x1234 x 0x5678 unsigned -> p=0x06260060 after 4 cycles. DIGIT=5 with WIDTH=16 -> elaboration error.
